// File: rtl/e203_int_evt_agg_pkg.sv
// Shared timing constants and FSM encoding for the interrupt event aggregator
// and its downstream pulse generator.
package e203_int_evt_agg_pkg;

  localparam int DEF_NUM_SRC     = 8;
  localparam int DEF_HOLDOFF_CYC = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_HOLD = 2'd2
  } agg_state_t;

endpackage

// File: rtl/e203_int_evt_agg_if.sv
// Event, mask/clear register and status/request bundle of the event aggregator.
interface e203_int_evt_agg_if #(
  parameter int NUM_SRC = e203_int_evt_agg_pkg::DEF_NUM_SRC
);
  logic [NUM_SRC-1:0] evt_in;
  logic               mask_wr_en;
  logic [NUM_SRC-1:0] mask_wr_data;
  logic               clr_en;
  logic [NUM_SRC-1:0] clr_data;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] ovf;
  logic               irq_pend;
  logic               pulse_start;
  logic               busy;

  modport master (
    output evt_in, mask_wr_en, mask_wr_data, clr_en, clr_data,
    input  mask, pending, ovf, irq_pend, pulse_start, busy
  );

  modport slave (
    input  evt_in, mask_wr_en, mask_wr_data, clr_en, clr_data,
    output mask, pending, ovf, irq_pend, pulse_start, busy
  );
endinterface

// File: rtl/e203_evt_edge_det.sv
// One event source: rising-edge detect, pending latch (set beats clear) and sticky overflow.
module e203_evt_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic evt,
  input  logic clr,
  output logic pending,
  output logic ovf
);

  logic evt_q;
  logic pend_q;
  logic ovf_q;
  logic edge_hit;

  // evt_q resets low so a level held through reset release is seen as an edge.
  assign edge_hit = evt & ~evt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_q  <= 1'b0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      evt_q <= evt;
      if (edge_hit)
        pend_q <= 1'b1;
      else if (clr)
        pend_q <= 1'b0;
      if (clr)
        ovf_q <= 1'b0;
      else if (edge_hit && pend_q)
        ovf_q <= 1'b1;
    end
  end

  assign pending = pend_q;
  assign ovf     = ovf_q;

endmodule

// File: rtl/e203_int_evt_agg.sv
// Aggregates per-source event edges into masked pending bits and issues one-cycle
// pulse_start requests, spaced by a hold-off so the pulse generator never overlaps.
module e203_int_evt_agg
  import e203_int_evt_agg_pkg::*;
#(
  parameter int NUM_SRC     = DEF_NUM_SRC,
  parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  e203_int_evt_agg_if.slave  bus
);

  localparam int CNT_W = $clog2(HOLDOFF_CYC + 1);

  logic [NUM_SRC-1:0] pend_w;
  logic [NUM_SRC-1:0] ovf_w;
  logic [NUM_SRC-1:0] mask_q;
  logic               irq_w;
  agg_state_t         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               pulse_q;
  logic               busy_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    e203_evt_edge_det u_det (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .evt     (bus.evt_in[i]),
      .clr     (bus.clr_en & bus.clr_data[i]),
      .pending (pend_w[i]),
      .ovf     (ovf_w[i])
    );
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)
      mask_q <= '0;
    else if (bus.mask_wr_en)
      mask_q <= bus.mask_wr_data;
  end

  assign irq_w = |(pend_w & mask_q);

  // Outputs are registered alongside the state so they change exactly with it.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (irq_w) begin
            state_q <= ST_FIRE;
            pulse_q <= 1'b1;
          end
        end
        ST_FIRE: begin
          cnt_q   <= CNT_W'(HOLDOFF_CYC - 1);
          state_q <= ST_HOLD;
          pulse_q <= 1'b0;
          busy_q  <= 1'b1;
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mask        = mask_q;
  assign bus.pending     = pend_w;
  assign bus.ovf         = ovf_w;
  assign bus.irq_pend    = irq_w;
  assign bus.pulse_start = pulse_q;
  assign bus.busy        = busy_q;

endmodule
